// File: rtl/stepper_pulse_gen_if.sv
// Command port of the stepper pulse generator: one signed move request with a
// valid/ready handshake, plus the level-sensitive abort line from the MMIO decode.
interface stepper_pulse_gen_if #(
   parameter int COUNT_W = 16,
   parameter int DIV_W   = 20
);
   logic                       cmd_valid;
   logic                       cmd_ready;
   logic signed [COUNT_W-1:0]  cmd_steps;
   logic        [DIV_W-1:0]    cmd_period;
   logic                       abort;

   // Processor / MMIO side issues moves and aborts
   modport master (
      output cmd_valid,
      output cmd_steps,
      output cmd_period,
      output abort,
      input  cmd_ready
   );

   // Pulse generator side consumes them
   modport slave (
      input  cmd_valid,
      input  cmd_steps,
      input  cmd_period,
      input  abort,
      output cmd_ready
   );
endinterface

// File: rtl/stepper_pulse_gen.sv
// STEP/DIR pulse generator for one stepper axis. Accepts a signed step count and a
// STEP period, holds DIR stable for a setup window, then emits fixed-width STEP
// pulses at the requested period (clamped so the low time never undercuts the
// high time). Progress is reported through busy/done/steps_left for polling.
module stepper_pulse_gen #(
   parameter int COUNT_W      = 16,
   parameter int DIV_W        = 20,
   parameter int PULSE_CYCLES = 100,
   parameter int DIR_SETUP    = 50
) (
   input  logic                clock,
   input  logic                reset,
   stepper_pulse_gen_if.slave  cmd,
   output logic                step_out,
   output logic                dir_out,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  steps_left
);

   // Shared down-counter must hold the widest of: low time, high time, DIR setup
   localparam int W_LO  = DIV_W + 1;
   localparam int W_HI  = $clog2(PULSE_CYCLES + 1);
   localparam int W_SU  = $clog2(DIR_SETUP + 1);
   localparam int W_AB  = (W_LO > W_HI) ? W_LO : W_HI;
   localparam int CNT_W = (W_AB > W_SU) ? W_AB : W_SU;

   // Counter reload values: a phase of N cycles counts N-1 down to 0
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP - 1);
   localparam logic [CNT_W-1:0] HI_LOAD    = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HI_TIME    = CNT_W'(PULSE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [COUNT_W-1:0] LEFT_ONE = COUNT_W'(1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SETUP    = 2'd1;
   localparam logic [1:0] PULSE_HI = 2'd2;
   localparam logic [1:0] PULSE_LO = 2'd3;

   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic [CNT_W-1:0]    lo_time;
   logic                step_nxt;
   logic                done_nxt;
   logic                abort_pend;
   logic                pend_nxt;
   logic                dec;
   logic                accept;
   logic [COUNT_W-1:0]  mag;
   logic [CNT_W-1:0]    lo_calc;

   // Magnitude of a two's-complement count; the most negative value maps to
   // 2^(COUNT_W-1), which is representable once the result is read as unsigned.
   function automatic logic [COUNT_W-1:0] abs_steps(input logic signed [COUNT_W-1:0] s);
      logic [COUNT_W-1:0] u;
      u = s;
      if (s[COUNT_W-1])
         abs_steps = (~u) + LEFT_ONE;
      else
         abs_steps = u;
   endfunction

   // Low time = max(period - high, high), evaluated wide enough that a short
   // period never wraps; this also guarantees a non-zero low phase.
   function automatic logic [CNT_W-1:0] calc_lo_time(input logic [DIV_W-1:0] period);
      logic [CNT_W-1:0] p_ext;
      p_ext = CNT_W'(period);
      if ((p_ext > HI_TIME) && ((p_ext - HI_TIME) > HI_TIME))
         calc_lo_time = p_ext - HI_TIME;
      else
         calc_lo_time = HI_TIME;
   endfunction

   assign accept        = cmd.cmd_valid && (state == IDLE);
   assign mag           = abs_steps(cmd.cmd_steps);
   assign lo_calc       = calc_lo_time(cmd.cmd_period);
   assign cmd.cmd_ready = (state == IDLE);
   assign busy          = (state != IDLE);

   // Next-state, counter and output decode for the move sequencer
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      step_nxt  = step_out;
      done_nxt  = 1'b0;
      pend_nxt  = abort_pend;
      dec       = 1'b0;
      case (state)
         IDLE: begin
            // Abort is ignored while idle; a zero-length move completes at once
            pend_nxt = 1'b0;
            step_nxt = 1'b0;
            if (accept) begin
               if (mag == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt = SETUP;
                  cnt_nxt   = SETUP_LOAD;
               end
            end
         end
         SETUP: begin
            if (cmd.abort) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (cnt == '0) begin
               state_nxt = PULSE_HI;
               cnt_nxt   = HI_LOAD;
               step_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         PULSE_HI: begin
            // An abort here is remembered so the pulse is never truncated
            if (cmd.abort)
               pend_nxt = 1'b1;
            if (cnt == '0) begin
               step_nxt = 1'b0;
               dec      = 1'b1;
               if (abort_pend || cmd.abort) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = PULSE_LO;
                  cnt_nxt   = lo_time - CNT_ONE;
               end
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         PULSE_LO: begin
            if (cmd.abort) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (cnt == '0) begin
               if (steps_left == '0) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = PULSE_HI;
                  cnt_nxt   = HI_LOAD;
                  step_nxt  = 1'b1;
               end
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            step_nxt  = 1'b0;
         end
      endcase
   end

   // Sequencer state and phase counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // STEP output register; reset drops it immediately mid-pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         step_out <= 1'b0;
      else
         step_out <= step_nxt;
   end

   // One-cycle completion pulse, raised on the first idle cycle after a move
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         done <= 1'b0;
      else
         done <= done_nxt;
   end

   // Abort request seen during a high phase, applied when that pulse ends
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         abort_pend <= 1'b0;
      else
         abort_pend <= pend_nxt;
   end

   // Command latches: DIR and low time change only on accept; steps_left also
   // counts down once per completed pulse and is kept after an abort
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dir_out    <= 1'b0;
         steps_left <= '0;
         lo_time    <= '0;
      end else if (accept) begin
         dir_out    <= cmd.cmd_steps[COUNT_W-1];
         steps_left <= mag;
         lo_time    <= lo_calc;
      end else if (dec) begin
         steps_left <= steps_left - LEFT_ONE;
      end
   end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed bench for stepper_pulse_gen with PULSE_CYCLES=4, DIR_SETUP=2.
// Each move is started on an accept edge (index 0 = sample taken 1 ns after that
// edge); per-cycle outputs are captured into bit masks and compared against
// hand-derived constants.
module tb_stepper_pulse_gen;
   localparam int COUNT_W = 16;
   localparam int DIV_W   = 20;

   logic clock;
   logic reset;
   logic step_out, dir_out, busy, done;
   logic [COUNT_W-1:0] steps_left;

   int total;
   int passed;
   int failed;

   logic [63:0] cap_step, cap_done, cap_busy, cap_dir, cap_ready;
   logic [COUNT_W-1:0] cap_left [0:63];

   stepper_pulse_gen_if #(.COUNT_W(COUNT_W), .DIV_W(DIV_W)) bus ();

   stepper_pulse_gen #(
      .COUNT_W(COUNT_W), .DIV_W(DIV_W), .PULSE_CYCLES(4), .DIR_SETUP(2)
   ) dut (
      .clock(clock), .reset(reset), .cmd(bus),
      .step_out(step_out), .dir_out(dir_out), .busy(busy),
      .done(done), .steps_left(steps_left)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a command, take it on the next edge, then capture n post-edge samples.
   // abort is raised from index abort_at on; from junk_from to junk_to a second
   // command is offered on the bus.
   task automatic run(input logic [COUNT_W-1:0] steps, input logic [DIV_W-1:0] period,
                      input int n, input int abort_at, input int junk_from, input int junk_to);
      bus.cmd_valid  = 1'b1;
      bus.cmd_steps  = steps;
      bus.cmd_period = period;
      @(posedge clock); #1;
      bus.cmd_valid = 1'b0;
      cap_step = '0; cap_done = '0; cap_busy = '0; cap_dir = '0; cap_ready = '0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clock); #1;
         end
         cap_step[i]  = step_out;
         cap_done[i]  = done;
         cap_busy[i]  = busy;
         cap_dir[i]   = dir_out;
         cap_ready[i] = bus.cmd_ready;
         cap_left[i]  = steps_left;
         bus.abort = (abort_at >= 0) && (i >= abort_at);
         if (i >= junk_from && i <= junk_to) begin
            bus.cmd_valid  = 1'b1;
            bus.cmd_steps  = 16'sd7;
            bus.cmd_period = 20'd20;
         end else begin
            bus.cmd_valid = 1'b0;
         end
      end
      bus.abort     = 1'b0;
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      total = 0; passed = 0; failed = 0;
      bus.cmd_valid = 1'b0; bus.cmd_steps = '0; bus.cmd_period = '0; bus.abort = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("rst_step",  64'(step_out), 64'h0);
      check("rst_dir",   64'(dir_out), 64'h0);
      check("rst_busy",  64'(busy), 64'h0);
      check("rst_done",  64'(done), 64'h0);
      check("rst_left",  64'(steps_left), 64'h0);
      check("rst_ready", 64'(bus.cmd_ready), 64'h1);
      reset = 1'b0;
      @(posedge clock); #1;

      // T1: 3 steps, period 10 -> rises at idx 2,12,22; done at idx 32
      run(16'd3, 20'd10, 40, -1, 99, -1);
      check("t1_step",   cap_step, 64'h0000_0000_03C0_F03C);
      check("t1_done",   cap_done, 64'h0000_0001_0000_0000);
      check("t1_busy",   cap_busy, 64'h0000_0000_FFFF_FFFF);
      check("t1_dir",    cap_dir,  64'h0);
      check("t1_left0",  64'(cap_left[0]),  64'd3);
      check("t1_left5",  64'(cap_left[5]),  64'd3);
      check("t1_left6",  64'(cap_left[6]),  64'd2);
      check("t1_left16", 64'(cap_left[16]), 64'd1);
      check("t1_left26", 64'(cap_left[26]), 64'd0);
      check("t1_ready",  cap_ready, 64'h0000_00FF_0000_0000);

      // T2: -2 steps -> DIR high, two pulses, done at idx 22
      run(16'hFFFE, 20'd10, 30, -1, 99, -1);
      check("t2_dir",   cap_dir,  64'h0000_0000_3FFF_FFFF);
      check("t2_left0", 64'(cap_left[0]), 64'd2);
      check("t2_step",  cap_step, 64'h0000_0000_0000_F03C);
      check("t2_done",  cap_done, 64'h0000_0000_0040_0000);

      // T3: period 3 clamps to 4 high / 4 low -> rises at idx 2,10; done at 18
      run(16'd2, 20'd3, 24, -1, 99, -1);
      check("t3_step", cap_step, 64'h0000_0000_0000_3C3C);
      check("t3_done", cap_done, 64'h0000_0000_0004_0000);

      // T3b: most negative count, aborted during DIR setup
      run(16'h8000, 20'd10, 6, 0, 99, -1);
      check("t3b_left0", 64'(cap_left[0]), 64'h8000);
      check("t3b_dir",   64'(cap_dir[0]), 64'h1);
      check("t3b_step",  cap_step, 64'h0);
      check("t3b_done",  cap_done, 64'h2);
      check("t3b_busy",  cap_busy, 64'h1);
      check("t3b_left5", 64'(cap_left[5]), 64'h8000);

      // T4: zero steps -> done at idx 0, never busy, ready throughout
      run(16'd0, 20'd10, 10, -1, 99, -1);
      check("t4_done",  cap_done,  64'h1);
      check("t4_busy",  cap_busy,  64'h0);
      check("t4_ready", cap_ready, 64'h3FF);
      check("t4_step",  cap_step,  64'h0);
      check("t4_left",  64'(cap_left[9]), 64'd0);

      // T5: abort during the second high phase -> pulse kept whole, done at idx 16
      run(16'd5, 20'd10, 30, 13, 99, -1);
      check("t5_step",   cap_step, 64'h0000_0000_0000_F03C);
      check("t5_done",   cap_done, 64'h0000_0000_0001_0000);
      check("t5_busy",   cap_busy, 64'h0000_0000_0000_FFFF);
      check("t5_left",   64'(cap_left[29]), 64'd3);

      // T6: second command offered while busy is ignored
      run(16'd3, 20'd10, 40, -1, 1, 20);
      check("t6_step",  cap_step,  64'h0000_0000_03C0_F03C);
      check("t6_done",  cap_done,  64'h0000_0001_0000_0000);
      check("t6_ready", cap_ready, 64'h0000_00FF_0000_0000);
      check("t6_left5", 64'(cap_left[5]), 64'd3);
      check("t6_dir",   cap_dir,   64'h0);

      // T6b: reset in the middle of a high phase
      run(16'hFFFD, 20'd10, 4, -1, 99, -1);
      check("t6b_hi",  64'(cap_step[3]), 64'h1);
      check("t6b_dir", 64'(cap_dir[3]),  64'h1);
      reset = 1'b1;
      #1;
      check("t6b_step_async", 64'(step_out), 64'h0);
      check("t6b_dir_rst",    64'(dir_out), 64'h0);
      check("t6b_busy_rst",   64'(busy), 64'h0);
      check("t6b_left_rst",   64'(steps_left), 64'h0);
      check("t6b_done_rst",   64'(done), 64'h0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      check("t6b_ready", 64'(bus.cmd_ready), 64'h1);
      check("t6b_done",  64'(done), 64'h0);
      check("t6b_step",  64'(step_out), 64'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
